// File: rtl/clock_pkg.sv
// Shared types and defaults for the CPU slow-clock controller.
package clock_pkg;

  localparam int FAST_CLK_HZ  = 12_000_000;
  localparam int CNT_W        = 32;
  localparam int STEP_LEN_DEF = FAST_CLK_HZ / 2000;  // 0.5 ms high time per single step

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } load_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/step_pulse.sv
// Pushbutton synchroniser, rising-edge detector and fixed-length single-step pulse timer.
module step_pulse #(
  parameter int STEP_LEN = 6000
) (
  input  logic fastClk,
  input  logic rst,
  input  logic step_btn,
  input  logic abort,
  output logic pulse_on
);

  localparam int SC_W = $clog2(STEP_LEN + 1);

  logic            sync1;
  logic            sync2;
  logic            btn_q;
  logic [SC_W-1:0] cnt;
  logic            edge_det;
  logic            fire;

  assign edge_det = sync2 & ~btn_q;
  // A press only starts a pulse when the timer is idle and nothing is gating the clock.
  assign fire     = edge_det & (cnt == '0) & ~abort;
  assign pulse_on = fire | (cnt != '0);

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      btn_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      btn_q <= sync2;
      if (abort)
        cnt <= '0;
      else if (fire)
        cnt <= SC_W'(STEP_LEN - 1);
      else if (cnt != '0)
        cnt <= cnt - SC_W'(1);
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Divider-load serialiser and CPU clock selection/gating for the slow clock generator.
//   state | meaning
//   IDLE  | ready for a new divider value
//   PRE   | mode high, bit 0, preamble cycles
//   SHIFT | mode high, divider bits out LSB first
//   GAP   | mode low settling time before next load
module clock_ctrl #(
  parameter int CNT_W    = clock_pkg::CNT_W,
  parameter int PRE_LEN  = 2,
  parameter int GAP_LEN  = 4,
  parameter int STEP_LEN = clock_pkg::STEP_LEN_DEF
) (
  input  logic             fastClk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             div_mode,
  output logic             div_bit,
  input  logic             slow_clk_i,
  input  logic             manual_sel,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_clk,
  output logic             busy
);

  import clock_pkg::*;

  localparam int PH_W = $clog2(max3(PRE_LEN, CNT_W, GAP_LEN) + 1);

  load_state_t      state;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] sreg;
  logic             manual_q;
  logic             hs;
  logic             mode_chg;
  logic             gate;
  logic             step_abort;
  logic             pulse_on;

  assign hs       = cfg_valid & cfg_ready;
  assign mode_chg = manual_sel ^ manual_q;
  // The handshake itself gates, so a load kills a step pulse on the very next cycle.
  assign gate       = hs | busy | halt | mode_chg;
  assign step_abort = gate | ~manual_sel;

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      sreg      <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      div_mode  <= 1'b0;
      div_bit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            state     <= PRE;
            phase     <= PH_W'(PRE_LEN - 1);
            sreg      <= cfg_data;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            div_mode  <= 1'b1;
            div_bit   <= 1'b0;
          end
        end
        PRE: begin
          if (phase == '0) begin
            state   <= SHIFT;
            phase   <= PH_W'(CNT_W - 1);
            div_bit <= sreg[0];
            sreg    <= sreg >> 1;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        SHIFT: begin
          if (phase == '0) begin
            state    <= GAP;
            phase    <= PH_W'(GAP_LEN - 1);
            div_mode <= 1'b0;
            div_bit  <= 1'b0;
          end else begin
            phase   <= phase - PH_W'(1);
            div_bit <= sreg[0];
            sreg    <= sreg >> 1;
          end
        end
        GAP: begin
          if (phase == '0) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  step_pulse #(
    .STEP_LEN (STEP_LEN)
  ) u_step (
    .fastClk  (fastClk),
    .rst      (rst),
    .step_btn (step_btn),
    .abort    (step_abort),
    .pulse_on (pulse_on)
  );

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      cpu_clk  <= 1'b0;
      manual_q <= 1'b0;
    end else begin
      manual_q <= manual_sel;
      if (gate)
        cpu_clk <= 1'b0;
      else if (manual_sel)
        cpu_clk <= pulse_on;
      else
        cpu_clk <= slow_clk_i;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed + randomised bench for clock_ctrl against a cycle-schedule reference model.
module tb_clock_ctrl;

  localparam int CW       = 32;
  localparam int PRE      = 2;
  localparam int GAP      = 4;
  localparam int STEP     = 8;
  localparam int MODE_HI  = PRE + CW;
  localparam int LOAD_CYC = PRE + CW + GAP + 1;
  localparam int RUN_MAX  = 128;

  logic          fastClk;
  logic          rst;
  logic [CW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          div_mode;
  logic          div_bit;
  logic          slow_clk_i;
  logic          manual_sel;
  logic          step_btn;
  logic          halt;
  logic          cpu_clk;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] vals [0:3];
  logic btn_s   [0:RUN_MAX-1];
  logic halt_s  [0:RUN_MAX-1];
  logic valid_s [0:RUN_MAX-1];
  logic slow_s  [0:RUN_MAX-1];
  logic obs_cpu [0:RUN_MAX];
  logic obs_rdy [0:RUN_MAX];

  clock_ctrl #(
    .CNT_W    (CW),
    .PRE_LEN  (PRE),
    .GAP_LEN  (GAP),
    .STEP_LEN (STEP)
  ) dut (
    .fastClk    (fastClk),
    .rst        (rst),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .div_mode   (div_mode),
    .div_bit    (div_bit),
    .slow_clk_i (slow_clk_i),
    .manual_sel (manual_sel),
    .step_btn   (step_btn),
    .halt       (halt),
    .cpu_clk    (cpu_clk),
    .busy       (busy)
  );

  initial fastClk = 1'b0;
  always #5 fastClk = ~fastClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge fastClk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives vals[0..nv-1] as a valid/ready master and checks the serial stream against
  // the expected frame: handshake every LOAD_CYC cycles, PRE zeros, CW data bits LSB first.
  task automatic load_seq(input string tag, input int nv, input int ncyc);
    int sent, j, m, mm_mode, mm_bit, mm_rdy, mm_busy, nhigh;
    logic rdy_before, em, eb, er;
    logic [CW-1:0] got;
    sent = 0; mm_mode = 0; mm_bit = 0; mm_rdy = 0; mm_busy = 0; nhigh = 0; got = '0;
    cfg_valid = 1'b1;
    cfg_data  = vals[0];
    for (int n = 1; n <= ncyc; n++) begin
      rdy_before = cfg_ready;
      tick();
      if (rdy_before && cfg_valid) sent++;
      cfg_valid = (sent < nv);
      cfg_data  = (sent < nv) ? vals[sent] : '0;
      j = (n - 1) / LOAD_CYC;
      m = n - LOAD_CYC * j;
      if (j < nv) begin
        em = (m <= MODE_HI);
        eb = (m > PRE && m <= MODE_HI) ? vals[j][m-PRE-1] : 1'b0;
        er = (m == LOAD_CYC);
      end else begin
        em = 1'b0; eb = 1'b0; er = 1'b1;
      end
      if (div_mode !== em) mm_mode++;
      if (div_bit !== eb) mm_bit++;
      if (cfg_ready !== er) mm_rdy++;
      if (busy !== !er) mm_busy++;
      if (div_mode === 1'b1) nhigh++;
      if (j == 0 && m > PRE && m <= MODE_HI) got[m-PRE-1] = div_bit;
    end
    cfg_valid = 1'b0;
    chk({tag, "_mode_trace"}, mm_mode, 0);
    chk({tag, "_bit_trace"}, mm_bit, 0);
    chk({tag, "_ready_trace"}, mm_rdy, 0);
    chk({tag, "_busy_trace"}, mm_busy, 0);
    chk({tag, "_mode_high_cycles"}, nhigh, MODE_HI * nv);
    chk({tag, "_first_word"}, got, vals[0]);
  endtask

  task automatic clear_sched();
    for (int c = 0; c < RUN_MAX; c++) begin
      btn_s[c] = 1'b0; halt_s[c] = 1'b0; valid_s[c] = 1'b0; slow_s[c] = 1'b0;
    end
  endtask

  // Plays the schedule, then predicts cpu_clk / cfg_ready from it:
  // free-run = slow clock one cycle late; single-step = STEP-long pulse starting
  // 3 cycles after a press; any gate cycle forces 0 next cycle and ends the pulse.
  task automatic run_sched(input string tag, input int n, input logic man);
    int next_ready, p_start, p_end, mm_cpu, mm_rdy;
    logic rdy, hs, gate, edge_c, exp_c;
    for (int c = 0; c < n; c++) begin
      step_btn   = btn_s[c];
      halt       = halt_s[c];
      cfg_valid  = valid_s[c];
      slow_clk_i = slow_s[c];
      tick();
      obs_cpu[c+1] = cpu_clk;
      obs_rdy[c+1] = cfg_ready;
    end
    step_btn = 1'b0; halt = 1'b0; cfg_valid = 1'b0;
    next_ready = 0; p_start = 0; p_end = -1; mm_cpu = 0; mm_rdy = 0;
    for (int c = 0; c < n; c++) begin
      rdy = (c >= next_ready);
      hs  = valid_s[c] && rdy;
      if (hs) next_ready = c + LOAD_CYC;
      gate = hs || !rdy || halt_s[c];
      if (obs_rdy[c+1] !== ((c + 1) >= next_ready)) mm_rdy++;
      if (man) begin
        edge_c = (c >= 2) ? (btn_s[c-2] && ((c >= 3) ? !btn_s[c-3] : 1'b1)) : 1'b0;
        if (gate) begin
          if (p_end >= c + 1) p_end = c;
          exp_c = 1'b0;
        end else begin
          if (edge_c && !(c >= p_start && c < p_end)) begin
            p_start = c + 1;
            p_end   = c + STEP;
          end
          exp_c = (c + 1 >= p_start) && (c + 1 <= p_end);
        end
      end else begin
        exp_c = gate ? 1'b0 : slow_s[c];
      end
      if (obs_cpu[c+1] !== exp_c) mm_cpu++;
    end
    chk({tag, "_cpu_trace"}, mm_cpu, 0);
    chk({tag, "_ready_trace"}, mm_rdy, 0);
  endtask

  function automatic int count_high(input int a, input int b);
    int k;
    k = 0;
    for (int i = a; i <= b; i++) if (obs_cpu[i] === 1'b1) k++;
    return k;
  endfunction

  function automatic int first_high(input int a, input int b);
    for (int i = a; i <= b; i++) if (obs_cpu[i] === 1'b1) return i;
    return -1;
  endfunction

  initial begin
    int ph, h0, hl, pr, fh;
    logic [CW-1:0] rv;
    rst = 1'b1; cfg_data = '0; cfg_valid = 1'b0; slow_clk_i = 1'b0;
    manual_sel = 1'b0; step_btn = 1'b0; halt = 1'b0;
    #3;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_div_mode", div_mode, 0);
    chk("rst_div_bit", div_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_clk", cpu_clk, 0);
    #4 rst = 1'b0;
    tick(); tick();

    vals[0] = 32'h0000_0005;
    load_seq("load5", 1, LOAD_CYC + 6);

    vals[0] = 32'h0000_00A5; vals[1] = 32'h0000_003C;
    load_seq("b2b", 2, 2 * LOAD_CYC + 6);

    vals[0] = $urandom;
    load_seq("rand", 1, LOAD_CYC + 3);

    // reset while data bit 10 is on the wire
    rv = $urandom;
    cfg_data = rv; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (PRE + 10) tick();
    chk("mid_shift_mode", div_mode, 1);
    chk("mid_shift_bit10", div_bit, rv[10]);
    rst = 1'b1;
    #1;
    chk("async_rst_div_mode", div_mode, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cpu_clk", cpu_clk, 0);
    @(negedge fastClk);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", cfg_ready, 1);
    vals[0] = 32'h0000_0001;
    load_seq("reload1", 1, LOAD_CYC + 3);

    // free-running with halt window, a load, and button noise that must be ignored
    clear_sched();
    ph = $urandom_range(0, 9);
    h0 = $urandom_range(20, 30);
    hl = $urandom_range(5, 12);
    for (int c = 0; c < 100; c++) begin
      slow_s[c] = (((c + ph) / 10) % 2) == 1;
      halt_s[c] = (c >= h0) && (c < h0 + hl);
      btn_s[c]  = ($urandom_range(0, 1) == 1);
    end
    valid_s[50] = 1'b1;
    run_sched("freerun", 100, 1'b0);
    chk("freerun_halt_window_high", count_high(h0 + 1, h0 + hl), 0);

    // leaving single-step blanks the clock for one cycle
    slow_clk_i = 1'b1;
    repeat (3) tick();
    chk("freerun_steady_high", cpu_clk, 1);
    manual_sel = 1'b1;
    repeat (3) tick();
    chk("manual_idle_low", cpu_clk, 0);
    manual_sel = 1'b0;
    tick();
    chk("modesw_blank", cpu_clk, 0);
    tick();
    chk("modesw_resume", cpu_clk, 1);

    manual_sel = 1'b1;
    slow_clk_i = 1'b0;
    repeat (4) tick();

    // single-step: pulse, ignored re-press, fresh pulse, press under halt, late pulse
    clear_sched();
    btn_s[5] = 1'b1;  btn_s[6] = 1'b1;
    btn_s[11] = 1'b1; btn_s[12] = 1'b1;
    btn_s[25] = 1'b1; btn_s[26] = 1'b1;
    pr = $urandom_range(38, 44);
    btn_s[pr] = 1'b1; btn_s[pr+1] = 1'b1;
    halt_s[pr+2] = 1'b1;
    btn_s[55] = 1'b1; btn_s[56] = 1'b1;
    for (int c = 0; c < 70; c++) slow_s[c] = ($urandom_range(0, 1) == 1);
    run_sched("step", 70, 1'b1);
    fh = first_high(1, 20);
    chk("step_first_high_cycle", fh, 8);
    chk("step_pulse_len_no_extend", count_high(1, 20), STEP);
    chk("step_second_pulse_len", count_high(21, 37), STEP);
    chk("step_halt_edge_no_pulse", count_high(38, 57), 0);

    // load during a pulse kills it; load coincident with a step edge wins
    clear_sched();
    btn_s[3] = 1'b1; btn_s[4] = 1'b1;
    valid_s[8] = 1'b1;
    btn_s[50] = 1'b1; btn_s[51] = 1'b1;
    valid_s[52] = 1'b1;
    run_sched("abort", 100, 1'b1);
    chk("abort_pulse_before", obs_cpu[8], 1);
    chk("abort_pulse_killed", obs_cpu[9], 0);
    chk("abort_no_clock_after", count_high(9, 100), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
